arb_requester: RTL

Requester-side companion to the round-robin arbiter. Each of NUM_PORTS ports buffers payloads in a private FIFO and raises a request line while that FIFO holds data. The block consumes the arbiter's one-hot grant, pops the granted port's head entry, and emits it on a single registered output channel. It sits between the per-port producers and the arbiter's req/gnt pair, and forms the data path the arbiter schedules.

---
 rtl/arb_req_pkg.sv | 22 ++
 rtl/arb_req_fifo.sv | 62 ++++++
 rtl/arb_requester.sv | 106 ++++++++++
 3 files changed

// File: rtl/arb_req_pkg.sv
// Shared width helpers and grant decode for the arbiter requester block.
package arb_req_pkg;

    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int lsb_index(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Per-port synchronous FIFO; head is read combinationally from the read pointer.
module arb_req_fifo
    import arb_req_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_i) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/arb_requester.sv
// Per-port FIFOs feeding a round-robin arbiter; pops the granted head onto one registered channel.
// ARB_REQ_GNT_CHECK_EN: reject illegal grants and flag them on sticky gnt_err_o.
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_PORTS-1:0]                  push_valid_i,
    input  logic [NUM_PORTS*DATA_W-1:0]           push_data_i,
    output logic [NUM_PORTS-1:0]                  push_ready_o,
    output logic [NUM_PORTS-1:0]                  req_o,
    input  logic [NUM_PORTS-1:0]                  gnt_i,
    output logic                                  out_valid_o,
    output logic [DATA_W-1:0]                     out_data_o,
    output logic [port_idx_w(NUM_PORTS)-1:0]      out_port_o,
    output logic                                  gnt_err_o
);
    localparam int PORT_IDX_W = port_idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0]             full, empty, push_fire, pop_sel;
    logic [NUM_PORTS-1:0][DATA_W-1:0] push_data, head;
    logic [PORT_IDX_W-1:0]            sel_idx;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [PORT_IDX_W-1:0] out_port_q, out_port_d;

    assign push_data    = push_data_i;
    assign push_ready_o = ~full;
    assign req_o        = ~empty;
    assign push_fire    = push_valid_i & ~full;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        arb_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push_i      (push_fire[i]),
            .push_data_i (push_data[i]),
            .pop_i       (pop_sel[i]),
            .head_o      (head[i]),
            .full_o      (full[i]),
            .empty_o     (empty[i])
        );
    end

`ifdef ARB_REQ_GNT_CHECK_EN
    logic gnt_err_q, gnt_err_d;
    logic gnt_onehot, gnt_legal;

    always_comb begin
        gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - NUM_PORTS'(1))) == '0);
        gnt_legal  = gnt_onehot && ((gnt_i & ~req_o) == '0);
        pop_sel    = gnt_legal ? gnt_i : '0;
        gnt_err_d  = gnt_err_q | ((gnt_i != '0) && !gnt_legal);
    end

    always_ff @(posedge clk) begin
        if (reset) gnt_err_q <= 1'b0;
        else       gnt_err_q <= gnt_err_d;
    end

    assign gnt_err_o = gnt_err_q;
`else
    logic [NUM_PORTS-1:0] gnt_masked;

    // Stray grant bits on idle ports are dropped; of what remains, the lowest index wins.
    always_comb begin
        gnt_masked = gnt_i & req_o;
        pop_sel    = gnt_masked & (~gnt_masked + NUM_PORTS'(1));
    end

    assign gnt_err_o = 1'b0;
`endif

    always_comb begin
        sel_idx     = PORT_IDX_W'(lsb_index(32'(pop_sel)));
        out_valid_d = |pop_sel;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        if (out_valid_d) begin
            out_data_d = head[sel_idx];
            out_port_d = sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_port_o  = out_port_q;

endmodule
